// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Purpose:
//   Moore control FSM for a shared-memory multicycle RV32I-subset datapath
//   (PC, IR, register file, ALU, unified memory). Supports lw, sw, R-type,
//   I-type ALU, jal and beq. Any other opcode, or an unsupported funct3 on an
//   ALU instruction, traps to ILLEGAL until reset. The controller drives every
//   datapath mux select and write enable, stalls on memory through
//   i_mem_ready, and counts retired instructions.
//
// Ports:
//   i_clk            system clock, all state on the rising edge
//   i_rst            synchronous active-high reset
//   i_op             IR[6:0]
//   i_funct3         IR[14:12]
//   i_funct7b5       IR[30]
//   i_zero           ALU zero flag, used in BEQ
//   i_mem_ready      memory completes its access this cycle
//   o_pc_write       load PC from the result bus
//   o_ir_write       load IR / old PC from memory read data
//   o_adr_src        memory address: 0=PC, 1=ALUOut
//   o_mem_write      memory write strobe
//   o_reg_write      register file write enable
//   o_result_src     result bus: 00=ALUOut, 01=mem data, 10=ALU result
//   o_alu_src_a      ALU A: 00=PC, 01=old PC, 10=rs1
//   o_alu_src_b      ALU B: 00=rs2, 01=imm, 10=const 4
//   o_imm_src        immediate format: 00=I, 01=S, 10=B, 11=J
//   o_alu_control    000 add, 001 sub, 010 and, 011 or, 101 slt
//   o_illegal_instr  trap flag, held until reset
//   o_retired        instructions completed since reset (wraps)
//
// States:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
//   DECODE   | read registers, compute branch/jump target into ALUOut
//   MEMADR   | compute load/store address rs1+imm
//   MEMREAD  | read data memory at ALUOut, wait for memory
//   MEMWB    | write loaded data into rd
//   MEMWRITE | write rs2 to memory at ALUOut, wait for memory
//   EXECR    | ALU on rs1, rs2
//   EXECI    | ALU on rs1, imm
//   ALUWB    | write ALUOut into rd
//   JAL      | PC <= target, compute PC+4 for rd
//   BEQ      | compare rs1, rs2; PC <= target if equal
//   ILLEGAL  | trap, all enables off until reset
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int RET_CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [6:0]           i_op,
    input  logic [2:0]           i_funct3,
    input  logic                 i_funct7b5,
    input  logic                 i_zero,
    input  logic                 i_mem_ready,
    output logic                 o_pc_write,
    output logic                 o_ir_write,
    output logic                 o_adr_src,
    output logic                 o_mem_write,
    output logic                 o_reg_write,
    output logic [1:0]           o_result_src,
    output logic [1:0]           o_alu_src_a,
    output logic [1:0]           o_alu_src_b,
    output logic [1:0]           o_imm_src,
    output logic [2:0]           o_alu_control,
    output logic                 o_illegal_instr,
    output logic [RET_CNT_W-1:0] o_retired
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [RET_CNT_W-1:0] RET_ONE = 1;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [RET_CNT_W-1:0]   r_retired;

    logic [2:0]             w_funct_alu;
    logic                   w_funct_ok;
    logic                   w_retire;

    logic                   w_pc_write;
    logic                   w_ir_write;
    logic                   w_mem_write;
    logic                   w_reg_write;

    // ALU operation for EXECR/EXECI. funct7b5 selects sub only for R-type,
    // since in I-type it is part of the immediate.
    always_comb begin
        w_funct_alu = ALU_ADD;
        w_funct_ok  = 1'b1;
        case (i_funct3)
            3'b000:  w_funct_alu = (r_state == S_EXECR && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_funct_alu = ALU_SLT;
            3'b110:  w_funct_alu = ALU_OR;
            3'b111:  w_funct_alu = ALU_AND;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    w_next_state = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECR;
                    OP_I:         w_next_state = S_EXECI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BEQ:       w_next_state = S_BEQ;
                    default:      w_next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next_state = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = i_mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = i_mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI:    w_next_state = w_funct_ok ? S_ALUWB : S_ILLEGAL;
            S_ALUWB:    w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_BEQ:      w_next_state = S_FETCH;
            S_ILLEGAL:  w_next_state = S_ILLEGAL;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        w_pc_write    = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        o_adr_src     = 1'b0;
        o_result_src  = 2'b00;
        o_alu_src_a   = 2'b00;
        o_alu_src_b   = 2'b00;
        o_alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                w_ir_write   = i_mem_ready;
                w_pc_write   = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                o_adr_src = 1'b1;
            end
            S_MEMWB: begin
                o_result_src = 2'b01;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe held for the whole stall; memory commits once on ready.
                o_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                o_alu_src_a   = 2'b10;
                o_alu_src_b   = 2'b00;
                o_alu_control = w_funct_alu;
            end
            S_EXECI: begin
                o_alu_src_a   = 2'b10;
                o_alu_src_b   = 2'b01;
                o_alu_control = w_funct_alu;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_JAL: begin
                // PC takes the target left in ALUOut by DECODE while the ALU
                // forms old PC + 4 for the rd write in ALUWB.
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
            end
            S_BEQ: begin
                o_alu_src_a   = 2'b10;
                o_alu_src_b   = 2'b00;
                o_alu_control = ALU_SUB;
                w_pc_write    = i_zero;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_imm_src = 2'b00;
        case (i_op)
            OP_SW:   o_imm_src = 2'b01;
            OP_BEQ:  o_imm_src = 2'b10;
            OP_JAL:  o_imm_src = 2'b11;
            default: o_imm_src = 2'b00;
        endcase
    end

    // Reset abandons the current instruction, so no write may escape in the
    // reset cycle itself.
    assign o_pc_write  = w_pc_write  & ~i_rst;
    assign o_ir_write  = w_ir_write  & ~i_rst;
    assign o_mem_write = w_mem_write & ~i_rst;
    assign o_reg_write = w_reg_write & ~i_rst;

    assign o_illegal_instr = (r_state == S_ILLEGAL);

    // An instruction retires on the edge that returns the FSM to FETCH.
    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                      (r_state == S_BEQ)   || (r_state == S_MEMWRITE && i_mem_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + RET_ONE;
        end
    end

    assign o_retired = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int RW = 4;

    // {pc_write, ir_write, adr_src, mem_write, reg_write, result_src, alu_src_a, alu_src_b, alu_control}
    localparam logic [13:0] V_FETCH    = 14'b1_1_0_0_0_10_00_10_000;
    localparam logic [13:0] V_FSTALL   = 14'b0_0_0_0_0_10_00_10_000;
    localparam logic [13:0] V_DECODE   = 14'b0_0_0_0_0_00_01_01_000;
    localparam logic [13:0] V_MEMADR   = 14'b0_0_0_0_0_00_10_01_000;
    localparam logic [13:0] V_MEMREAD  = 14'b0_0_1_0_0_00_00_00_000;
    localparam logic [13:0] V_MEMWB    = 14'b0_0_0_0_1_01_00_00_000;
    localparam logic [13:0] V_MEMWRITE = 14'b0_0_1_1_0_00_00_00_000;
    localparam logic [13:0] V_EXECR    = 14'b0_0_0_0_0_00_10_00_000;
    localparam logic [13:0] V_EXECI    = 14'b0_0_0_0_0_00_10_01_000;
    localparam logic [13:0] V_ALUWB    = 14'b0_0_0_0_1_00_00_00_000;
    localparam logic [13:0] V_JAL      = 14'b1_0_0_0_0_00_01_10_000;
    localparam logic [13:0] V_BEQ_T    = 14'b1_0_0_0_0_00_10_00_001;
    localparam logic [13:0] V_BEQ_N    = 14'b0_0_0_0_0_00_10_00_001;
    localparam logic [13:0] V_IDLE     = 14'b0;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    op;
    logic [2:0]    funct3;
    logic          funct7b5;
    logic          zero;
    logic          mem_ready;
    logic          pc_write, ir_write, adr_src, mem_write, reg_write;
    logic [1:0]    result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]    alu_control;
    logic          illegal_instr;
    logic [RW-1:0] retired;

    int passed = 0;
    int total  = 0;

    logic [13:0] w_ctl;
    assign w_ctl = {pc_write, ir_write, adr_src, mem_write, reg_write,
                    result_src, alu_src_a, alu_src_b, alu_control};

    always #5 clk = ~clk;

    multicycle_controller #(.RET_CNT_W(RW)) dut (
        .i_clk(clk), .i_rst(rst), .i_op(op), .i_funct3(funct3), .i_funct7b5(funct7b5),
        .i_zero(zero), .i_mem_ready(mem_ready),
        .o_pc_write(pc_write), .o_ir_write(ir_write), .o_adr_src(adr_src),
        .o_mem_write(mem_write), .o_reg_write(reg_write), .o_result_src(result_src),
        .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_imm_src(imm_src),
        .o_alu_control(alu_control), .o_illegal_instr(illegal_instr), .o_retired(retired)
    );

    // Every task starts and ends at a falling edge with the DUT in FETCH.

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({pc_write, ir_write, mem_write, reg_write} !== 4'b0000)
            $display("FAIL reset_enables: got %b expected 0000", {pc_write, ir_write, mem_write, reg_write});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (w_ctl !== V_FETCH) $display("FAIL reset_fetch: got %b expected %b", w_ctl, V_FETCH);
        else passed++;
        total++;
        if (retired !== 4'd0 || illegal_instr !== 1'b0)
            $display("FAIL reset_state: got retired=%0d illegal=%b expected 0/0", retired, illegal_instr);
        else passed++;
    endtask

    task automatic test_add();
        logic [13:0] ev [4];
        ev = '{V_FETCH, V_DECODE, V_EXECR, V_ALUWB};
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (w_ctl !== ev[i]) $display("FAIL add_cyc%0d: got %b expected %b", i, w_ctl, ev[i]);
            else passed++;
            @(negedge clk);
        end
        #1;
        total++;
        if (retired !== 4'd1) $display("FAIL add_retired: got %0d expected 1", retired);
        else passed++;
    endtask

    task automatic test_alu_ops();
        logic [6:0]  c_op  [5];
        logic [2:0]  c_f3  [5];
        logic        c_f7  [5];
        logic [13:0] c_ex  [5];
        logic [13:0] ev    [4];
        c_op = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011};
        c_f3 = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b000};
        c_f7 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        c_ex = '{V_EXECR | 14'd1, V_EXECR | 14'd5, V_EXECR | 14'd3, V_EXECR | 14'd2, V_EXECI};
        for (int c = 0; c < 5; c++) begin
            op = c_op[c]; funct3 = c_f3[c]; funct7b5 = c_f7[c]; mem_ready = 1'b1;
            ev = '{V_FETCH, V_DECODE, c_ex[c], V_ALUWB};
            for (int i = 0; i < 4; i++) begin
                #1;
                total++;
                if (w_ctl !== ev[i]) $display("FAIL alu_case%0d_cyc%0d: got %b expected %b", c, i, w_ctl, ev[i]);
                else passed++;
                @(negedge clk);
            end
        end
        #1;
        total++;
        if (retired !== 4'd6) $display("FAIL alu_retired: got %0d expected 6", retired);
        else passed++;
    endtask

    task automatic test_lw_stall();
        logic [13:0] ev [8];
        logic [7:0]  mr;
        int adr_cnt = 0;
        int wb_cnt  = 0;
        ev = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMREAD, V_MEMREAD, V_MEMREAD, V_MEMWB};
        mr = 8'b1100_0111;   // bit i = mem_ready in cycle i
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (w_ctl !== ev[i]) $display("FAIL lw_cyc%0d: got %b expected %b", i, w_ctl, ev[i]);
            else passed++;
            if (adr_src) adr_cnt++;
            if (reg_write) wb_cnt++;
            if (i == 1) begin
                total++;
                if (imm_src !== 2'b00) $display("FAIL lw_imm: got %b expected 00", imm_src);
                else passed++;
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (adr_cnt != 4 || wb_cnt != 1)
            $display("FAIL lw_counts: got adr=%0d wb=%0d expected 4/1", adr_cnt, wb_cnt);
        else passed++;
        total++;
        if (w_ctl !== V_FETCH || retired !== 4'd7)
            $display("FAIL lw_end: got %b retired=%0d expected %b retired=7", w_ctl, retired, V_FETCH);
        else passed++;
    endtask

    task automatic test_sw_stall();
        logic [13:0] ev [6];
        logic [5:0]  mr;
        int wr_cnt = 0;
        int rw_cnt = 0;
        ev = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWRITE, V_MEMWRITE, V_MEMWRITE};
        mr = 6'b100_111;
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (w_ctl !== ev[i]) $display("FAIL sw_cyc%0d: got %b expected %b", i, w_ctl, ev[i]);
            else passed++;
            if (mem_write) wr_cnt++;
            if (reg_write) rw_cnt++;
            if (i == 1) begin
                total++;
                if (imm_src !== 2'b01) $display("FAIL sw_imm: got %b expected 01", imm_src);
                else passed++;
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (wr_cnt != 3 || rw_cnt != 0)
            $display("FAIL sw_counts: got mem_write=%0d reg_write=%0d expected 3/0", wr_cnt, rw_cnt);
        else passed++;
        total++;
        if (w_ctl !== V_FETCH || retired !== 4'd8)
            $display("FAIL sw_end: got %b retired=%0d expected %b retired=8", w_ctl, retired, V_FETCH);
        else passed++;
    endtask

    task automatic test_jal();
        logic [13:0] ev [5];
        logic [4:0]  mr;
        ev = '{V_FSTALL, V_FETCH, V_DECODE, V_JAL, V_ALUWB};
        mr = 5'b11110;
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (w_ctl !== ev[i]) $display("FAIL jal_cyc%0d: got %b expected %b", i, w_ctl, ev[i]);
            else passed++;
            @(negedge clk);
        end
        #1;
        total++;
        if (imm_src !== 2'b11 || retired !== 4'd9)
            $display("FAIL jal_end: got imm=%b retired=%0d expected 11/9", imm_src, retired);
        else passed++;
    endtask

    task automatic test_beq();
        logic [13:0] ev [3];
        op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            zero = (t == 0);
            ev = '{V_FETCH, V_DECODE, (t == 0) ? V_BEQ_T : V_BEQ_N};
            for (int i = 0; i < 3; i++) begin
                #1;
                total++;
                if (w_ctl !== ev[i]) $display("FAIL beq_z%0d_cyc%0d: got %b expected %b", 1 - t, i, w_ctl, ev[i]);
                else passed++;
                @(negedge clk);
            end
        end
        zero = 1'b0;
        #1;
        total++;
        if (imm_src !== 2'b10 || retired !== 4'd11)
            $display("FAIL beq_end: got imm=%b retired=%0d expected 10/11", imm_src, retired);
        else passed++;
    endtask

    task automatic test_illegal();
        op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
        @(negedge clk);   // FETCH -> DECODE
        @(negedge clk);   // DECODE -> ILLEGAL
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (w_ctl !== V_IDLE || illegal_instr !== 1'b1)
                $display("FAIL illegal_cyc%0d: got %b flag=%b expected %b flag=1", i, w_ctl, illegal_instr, V_IDLE);
            else passed++;
            @(negedge clk);
        end
        #1;
        total++;
        if (retired !== 4'd11) $display("FAIL illegal_retired: got %0d expected 11", retired);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (illegal_instr !== 1'b0 || retired !== 4'd0 || w_ctl !== V_FETCH)
            $display("FAIL illegal_clear: got flag=%b retired=%0d ctl=%b expected 0/0/%b",
                     illegal_instr, retired, w_ctl, V_FETCH);
        else passed++;
    endtask

    task automatic test_bad_funct();
        op = 7'b0110011; funct3 = 3'b001; funct7b5 = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);   // in EXECR
        @(negedge clk);
        #1;
        total++;
        if (illegal_instr !== 1'b1 || reg_write !== 1'b0)
            $display("FAIL bad_funct: got flag=%b reg_write=%b expected 1/0", illegal_instr, reg_write);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
        @(negedge clk);   // DECODE
        @(negedge clk);   // EXECR
        @(negedge clk);   // ALUWB
        rst = 1'b1;
        #1;
        total++;
        if (reg_write !== 1'b0) $display("FAIL reset_mid_write: got %b expected 0", reg_write);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (w_ctl !== V_FETCH || retired !== 4'd0)
            $display("FAIL reset_mid_end: got %b retired=%0d expected %b retired=0", w_ctl, retired, V_FETCH);
        else passed++;
    endtask

    task automatic test_back_to_back_wrap();
        op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            repeat (3) @(negedge clk);
            #1;
            if (n == 15) begin
                total++;
                if (retired !== 4'd15) $display("FAIL wrap_pre: got %0d expected 15", retired);
                else passed++;
            end
        end
        total++;
        if (retired !== 4'd0) $display("FAIL wrap: got %0d expected 0", retired);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_lw_stall();
        test_sw_stall();
        test_jal();
        test_beq();
        test_illegal();
        test_bad_funct();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
